bram_stream_loader: RTL and testbench
=====================================

// Module: bram_stream_loader
// PURPOSE
//  Streams AXI-Stream words into a BRAM region through a BRAM_CTRL-type master port.
//  Its BRAM master port feeds P1 of the downstream BRAM mux.
//  Busy is the mux select, so the loader owns the BRAM only while a load is in flight.
//  Used to preload weights/buffers before the HLS core takes the memory back on P0.
// PARAMETERS
//  ADDR_WIDTH  32  BRAM byte-address width
//  DATA_WIDTH  32  word width; stream tdata width
//  WEN_WIDTH   DATA_WIDTH/8 (+1 if DATA_WIDTH%8)  byte-write-enable width
//  CNT_WIDTH   16  word-count width
//  ADDR_STEP   DATA_WIDTH/8 (+1 if DATA_WIDTH%8)  address increment per word, in bytes
// PORTS
//  Clk          in   1           single clock; also forwarded to M_Clk
//  Rst_n        in   1           synchronous, active-low reset
//  start        in   1           one-cycle request to begin a load (sampled in IDLE only)
//  base_addr    in   ADDR_WIDTH  first byte address, latched on start
//  word_count   in   CNT_WIDTH   words to write, latched on start
//  busy         out  1           high from the accepted start until DONE exits; drives mux sel
//  done         out  1           one-cycle pulse when a load finishes
//  err          out  1           sticky tlast mismatch flag; cleared on the next accepted start
//  words_done   out  CNT_WIDTH   words written in the current/last load
//  checksum     out  DATA_WIDTH  sum of words written (see CONFIGURATION)
//  s_tdata      in   DATA_WIDTH  stream data
//  s_tvalid     in   1           stream valid
//  s_tready     out  1           stream ready
//  s_tlast      in   1           stream end-of-packet
//  M_Addr       out  ADDR_WIDTH  BRAM byte address
//  M_EN         out  1           BRAM enable
//  M_Din        out  DATA_WIDTH  BRAM write data
//  M_Dout       in   DATA_WIDTH  BRAM read data; unused, ignored
//  M_WEN        out  WEN_WIDTH   BRAM byte-write-enables
//  M_Clk        out  1           equals Clk
//  M_Rst        out  1           equals ~Rst_n
// BEHAVIOUR
//  Reset (Rst_n=0 at posedge): outputs and state return to their reset values.
//    - state=IDLE; busy, done, err, s_tready, M_EN = 0
//    - M_WEN, M_Addr, M_Din, words_done, checksum = 0
//  FSM states: IDLE, LOAD, FLUSH, DONE.
//  IDLE
//    - s_tready=0.
//    - start=1: latch base_addr/word_count; clear err, words_done, checksum; busy<=1.
//    - If word_count==0, go to DONE; otherwise go to LOAD.
//  LOAD
//    - s_tready=1. A beat is accepted when s_tvalid&&s_tready.
//    - For the beat with index i (0-based), next cycle registers M_EN=1, M_WEN=all 1s,
//      M_Addr=base+i*ADDR_STEP (mod 2^ADDR_WIDTH, wraps silently), M_Din=s_tdata.
//    - Write latency is 1 cycle after the handshake.
//    - M_EN and M_WEN are 0 in any cycle following a non-accepted cycle.
//    - words_done increments with every accepted beat.
//    - Beat i==word_count-1 accepted: go to FLUSH, s_tready drops the same edge.
//      If s_tlast==0 on that beat, set err.
//    - Early end: s_tlast=1 on a beat i<word_count-1. Write that beat, set err, go to FLUSH.
//  FLUSH
//    - One cycle; the last write is on the port; s_tready=0; go to DONE.
//  DONE
//    - done=1 for one cycle, M_EN=0, busy<=0 at the exiting edge, go to IDLE.
//    - busy stays high through the last write, so the mux never switches mid-write.
//  Other rules
//    - start while not IDLE is ignored.
//    - Extra stream beats after the count are not accepted (s_tready=0).
//    - Reset mid-LOAD aborts immediately with no done pulse.
//      BRAM contents already written are left as-is.
//    - Max load is 2^CNT_WIDTH-1 words; words_done never wraps within a load.
// CONFIGURATION
//  BRAM_LOADER_CHECKSUM_EN
//    - Defined: checksum <= checksum + s_tdata on every accepted beat
//      (mod 2^DATA_WIDTH); cleared on start and reset.
//    - Not defined: the checksum port exists but is tied to 0 and no adder is built.
// TESTING
//  T1 basic load
//    - base=0x100, count=4, stream 0xA0..0xA3 with tlast on the 4th beat, tvalid held high
//    - -> writes at 0x100,0x104,0x108,0x10C, each 1 cycle after its handshake
//    - -> done pulse 2 cycles after the 4th handshake; err=0; words_done=4
//    - -> checksum=0x286 if the macro is enabled, else 0
//  T2 backpressure gaps
//    - tvalid toggles 1,0,0,1,...
//    - -> M_EN high only in cycles following accepted beats; addresses contiguous; no duplicates
//  T3 early tlast
//    - count=8, tlast on beat 3
//    - -> 3 writes, err=1, words_done=3, done pulse; 4th stream beat not accepted
//  T4 missing tlast / zero count
//    - count=2 with no tlast -> 2 writes, err=1
//    - count=0 -> done 1 cycle after start, no M_EN, s_tready never high
//  T5 start while busy / address wrap
//    - second start mid-load -> ignored, original base/count kept
//    - base=0xFFFFFFF8, count=3 -> addresses 0xFFFFFFF8,0xFFFFFFFC,0x00000000
//  T6 reset mid-load
//    - Rst_n=0 after 2 of 5 beats
//    - -> next cycle all outputs 0, busy=0, no done pulse
//    - -> a fresh start then loads normally

Source files
------------

// File: rtl/bram_stream_loader.sv
// AXI-Stream to BRAM_CTRL-port loader; owns the BRAM (busy = mux select) only while a load runs.
// Optional feature macro: BRAM_LOADER_CHECKSUM_EN (running sum of written words on checksum).
//
//  state | meaning
//  IDLE  | waiting for start; stream not ready
//  LOAD  | accepting beats, one BRAM write per accepted beat
//  FLUSH | last write is on the port; stream not ready
//  DONE  | done pulse; busy drops when this state exits
module bram_stream_loader #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int WEN_WIDTH  = DATA_WIDTH / 8 + (((DATA_WIDTH % 8) != 0) ? 1 : 0),
    parameter int CNT_WIDTH  = 16,
    parameter int ADDR_STEP  = DATA_WIDTH / 8 + (((DATA_WIDTH % 8) != 0) ? 1 : 0)
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [CNT_WIDTH-1:0]  word_count,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [CNT_WIDTH-1:0]  words_done,
    output logic [DATA_WIDTH-1:0] checksum,
    input  logic [DATA_WIDTH-1:0] s_tdata,
    input  logic                  s_tvalid,
    output logic                  s_tready,
    input  logic                  s_tlast,
    output logic [ADDR_WIDTH-1:0] M_Addr,
    output logic                  M_EN,
    output logic [DATA_WIDTH-1:0] M_Din,
    input  logic [DATA_WIDTH-1:0] M_Dout,
    output logic [WEN_WIDTH-1:0]  M_WEN,
    output logic                  M_Clk,
    output logic                  M_Rst
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic                  busy_q, busy_d;
    logic                  err_q, err_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0]  words_q, words_d;
    logic [ADDR_WIDTH-1:0] next_addr_q, next_addr_d;
    logic                  m_en_q, m_en_d;
    logic [WEN_WIDTH-1:0]  m_wen_q, m_wen_d;
    logic [ADDR_WIDTH-1:0] m_addr_q, m_addr_d;
    logic [DATA_WIDTH-1:0] m_din_q, m_din_d;

    logic accept;
    logic last_beat;
    logic start_ok;

    // Read data is never consumed; the loader only writes.
    logic unused_dout;
    assign unused_dout = ^M_Dout;

    assign s_tready  = (state_q == S_LOAD);
    assign accept    = s_tvalid && s_tready;
    assign last_beat = (words_q == (cnt_q - CNT_WIDTH'(1)));
    assign start_ok  = (state_q == S_IDLE) && start;

    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        err_d       = err_q;
        cnt_d       = cnt_q;
        words_d     = words_q;
        next_addr_d = next_addr_q;
        m_en_d      = 1'b0;
        m_wen_d     = '0;
        m_addr_d    = m_addr_q;
        m_din_d     = m_din_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cnt_d       = word_count;
                    next_addr_d = base_addr;
                    err_d       = 1'b0;
                    words_d     = '0;
                    busy_d      = 1'b1;
                    state_d     = (word_count == '0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                if (accept) begin
                    m_en_d      = 1'b1;
                    m_wen_d     = '1;
                    m_addr_d    = next_addr_q;
                    m_din_d     = s_tdata;
                    next_addr_d = next_addr_q + ADDR_WIDTH'(ADDR_STEP);
                    words_d     = words_q + CNT_WIDTH'(1);
                    if (last_beat) begin
                        state_d = S_FLUSH;
                        if (!s_tlast) begin
                            err_d = 1'b1;
                        end
                    end else if (s_tlast) begin
                        err_d   = 1'b1;
                        state_d = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
            words_q     <= '0;
            next_addr_q <= '0;
            m_en_q      <= 1'b0;
            m_wen_q     <= '0;
            m_addr_q    <= '0;
            m_din_q     <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
            words_q     <= words_d;
            next_addr_q <= next_addr_d;
            m_en_q      <= m_en_d;
            m_wen_q     <= m_wen_d;
            m_addr_q    <= m_addr_d;
            m_din_q     <= m_din_d;
        end
    end

`ifdef BRAM_LOADER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] sum_q, sum_d;

    always_comb begin
        sum_d = sum_q;
        if (start_ok) begin
            sum_d = '0;
        end else if (accept) begin
            sum_d = sum_q + s_tdata;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign checksum = sum_q;
`else
    logic unused_start_ok;
    assign unused_start_ok = start_ok;
    assign checksum = '0;
`endif

    assign busy       = busy_q;
    assign done       = (state_q == S_DONE);
    assign err        = err_q;
    assign words_done = words_q;
    assign M_EN       = m_en_q;
    assign M_WEN      = m_wen_q;
    assign M_Addr     = m_addr_q;
    assign M_Din      = m_din_q;
    assign M_Clk      = Clk;
    assign M_Rst      = ~Rst_n;

endmodule

// File: tb/tb_bram_stream_loader.sv
// Self-checking bench for bram_stream_loader: directed cases plus random loads against
// a cycle-indexed event model (expected writes, done cycle, busy window).
`timescale 1ns/1ps
module tb_bram_stream_loader;

    localparam int STEP = 4;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] base_addr = '0;
    logic [15:0] word_count = '0;
    logic        busy, done, err;
    logic [15:0] words_done;
    logic [31:0] checksum;
    logic [31:0] s_tdata = '0;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic        s_tlast = 1'b0;
    logic [31:0] M_Addr;
    logic        M_EN;
    logic [31:0] M_Din;
    logic [31:0] M_Dout = 32'hDEAD_BEEF;
    logic [3:0]  M_WEN;
    logic        M_Clk, M_Rst;

    bram_stream_loader dut (
        .Clk(Clk), .Rst_n(Rst_n), .start(start), .base_addr(base_addr),
        .word_count(word_count), .busy(busy), .done(done), .err(err),
        .words_done(words_done), .checksum(checksum), .s_tdata(s_tdata),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
        .M_Addr(M_Addr), .M_EN(M_EN), .M_Din(M_Din), .M_Dout(M_Dout),
        .M_WEN(M_WEN), .M_Clk(M_Clk), .M_Rst(M_Rst)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    typedef struct {
        int          c;
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    wr_t         exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    bit          chk_en = 1'b0;
    int          m_busy_lo = 1;
    int          m_busy_hi = 0;
    int          m_done_cyc = -1;
    bit          m_ready = 1'b0;
    bit          m_err = 1'b0;
    logic [15:0] m_words = '0;
    logic [31:0] m_sum = '0;
    int          wr_seen = 0;
    logic [31:0] last_addr = '0;
    logic [31:0] dat[16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d actual=0x%0h required=0x%0h", name, cyc, act, exp);
        end
    endtask

    always @(negedge Clk) begin
        logic        exp_en;
        logic [31:0] exp_ck;
        if (chk_en) begin
            exp_en = (exp_q.size() > 0) && (exp_q[0].c == cyc);
`ifdef BRAM_LOADER_CHECKSUM_EN
            exp_ck = m_sum;
`else
            exp_ck = 32'h0;
`endif
            chk("busy", busy, (cyc >= m_busy_lo) && (cyc <= m_busy_hi));
            chk("done", done, cyc == m_done_cyc);
            chk("s_tready", s_tready, m_ready);
            chk("err", err, m_err);
            chk("words_done", words_done, m_words);
            chk("checksum", checksum, exp_ck);
            chk("M_EN", M_EN, exp_en);
            chk("M_Rst", M_Rst, !Rst_n);
            chk("M_Clk", M_Clk, Clk);
            if (exp_en) begin
                chk("M_Addr", M_Addr, exp_q[0].a);
                chk("M_Din", M_Din, exp_q[0].d);
                chk("M_WEN", M_WEN, 4'hF);
                void'(exp_q.pop_front());
            end else begin
                chk("M_WEN_idle", M_WEN, 4'h0);
            end
            if (M_EN) begin
                wr_seen++;
                last_addr = M_Addr;
            end
        end
    end

    // vprob: percent chance of tvalid per cycle; 200 selects the 1,0,0 repeating pattern.
    // abort_after > 0 pulls Rst_n low once that many beats have been accepted.
    task automatic run_load(input logic [31:0] base, input int count, input int tlast_pos,
                            input int vprob, input bit extra_start, input int abort_after);
        int          n;
        int          beat;
        int          k;
        bit          e_err;
        logic [31:0] a;
        n = (count == 0) ? 0 : ((tlast_pos < count) ? tlast_pos + 1 : count);
        e_err = (count != 0) && (tlast_pos != count - 1);
        start = 1'b1;
        base_addr = base;
        word_count = 16'(count);
        @(posedge Clk); #1;
        start = 1'b0;
        base_addr = $urandom;
        word_count = 16'($urandom);
        m_busy_lo = cyc;
        m_err = 1'b0;
        m_words = '0;
        m_sum = '0;
        if (n == 0) begin
            m_done_cyc = cyc;
            m_busy_hi = cyc;
        end else begin
            m_ready = 1'b1;
            m_busy_hi = cyc + 1000000;
            m_done_cyc = -1;
        end
        beat = 0;
        k = 0;
        while (beat < n) begin
            if (vprob == 200) s_tvalid = ((k % 3) == 0);
            else s_tvalid = ($urandom_range(99) < 32'(vprob));
            s_tdata = dat[beat];
            s_tlast = (beat == tlast_pos);
            if (extra_start && k == 1) begin
                start = 1'b1;
                base_addr = 32'h0000_5000;
                word_count = 16'd1;
            end
            @(posedge Clk); #1;
            start = 1'b0;
            k++;
            if (s_tvalid) begin
                a = base + 32'(beat * STEP);
                exp_q.push_back('{cyc, a, dat[beat]});
                m_sum = m_sum + dat[beat];
                m_words = m_words + 16'd1;
                beat++;
                if (beat == n) begin
                    m_ready = 1'b0;
                    m_err = e_err;
                    m_done_cyc = cyc + 1;
                    m_busy_hi = cyc + 1;
                end
            end
            if (abort_after > 0 && beat == abort_after) begin
                s_tvalid = 1'b0;
                s_tlast = 1'b0;
                Rst_n = 1'b0;
                @(posedge Clk); #1;
                m_ready = 1'b0;
                m_words = '0;
                m_sum = '0;
                m_err = 1'b0;
                m_busy_hi = cyc - 1;
                m_done_cyc = -1;
                chk("abort_busy", busy, 0);
                chk("abort_done", done, 0);
                chk("abort_M_EN", M_EN, 0);
                chk("abort_M_Addr", M_Addr, 0);
                chk("abort_words", words_done, 0);
                Rst_n = 1'b1;
                return;
            end
            if (k > 2000) begin
                $display("FAIL load_timeout cyc=%0d actual=%0d beats required=%0d beats", cyc, beat, n);
                $fatal(1, "stimulus loop exceeded its cycle budget");
            end
        end
        s_tvalid = 1'b1;
        s_tlast = 1'($urandom_range(1));
        while (cyc <= m_done_cyc) begin
            s_tdata = $urandom;
            @(posedge Clk); #1;
        end
        s_tvalid = 1'b0;
        s_tlast = 1'b0;
    endtask

    initial begin
        int w0;
        int cnt;
        int tp;
        int r;
        repeat (3) @(posedge Clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_tready", s_tready, 0);
        chk("rst_M_EN", M_EN, 0);
        chk("rst_M_WEN", M_WEN, 0);
        chk("rst_M_Addr", M_Addr, 0);
        chk("rst_M_Din", M_Din, 0);
        chk("rst_words", words_done, 0);
        chk("rst_checksum", checksum, 0);
        chk("rst_M_Rst", M_Rst, 1);
        Rst_n = 1'b1;
        chk_en = 1'b1;
        @(posedge Clk); #1;

        for (int i = 0; i < 16; i++) dat[i] = 32'hA0 + 32'(i);
        w0 = wr_seen;
        run_load(32'h100, 4, 3, 100, 1'b0, 0);
        chk("t1_words", words_done, 4);
        chk("t1_err", err, 0);
        chk("t1_writes", wr_seen - w0, 4);
        chk("t1_last_addr", last_addr, 32'h10C);
`ifdef BRAM_LOADER_CHECKSUM_EN
        chk("t1_checksum", checksum, 32'h286);
`else
        chk("t1_checksum", checksum, 32'h0);
`endif

        for (int i = 0; i < 16; i++) dat[i] = $urandom;
        w0 = wr_seen;
        run_load(32'h2000, 6, 5, 200, 1'b0, 0);
        chk("t2_writes", wr_seen - w0, 6);
        chk("t2_last_addr", last_addr, 32'h2014);

        w0 = wr_seen;
        run_load(32'h3000, 8, 2, 70, 1'b0, 0);
        chk("t3_words", words_done, 3);
        chk("t3_err", err, 1);
        chk("t3_writes", wr_seen - w0, 3);

        w0 = wr_seen;
        run_load(32'h4000, 2, 99, 100, 1'b0, 0);
        chk("t4_err", err, 1);
        chk("t4_writes", wr_seen - w0, 2);
        w0 = wr_seen;
        run_load(32'h4100, 0, 99, 100, 1'b0, 0);
        chk("t4_zero_writes", wr_seen - w0, 0);
        chk("t4_zero_err", err, 0);

        run_load(32'h6000, 3, 2, 100, 1'b1, 0);
        chk("t5_last_addr", last_addr, 32'h6008);
        chk("t5_words", words_done, 3);
        run_load(32'hFFFF_FFF8, 3, 2, 100, 1'b0, 0);
        chk("t5_wrap_addr", last_addr, 32'h0);

        run_load(32'h7000, 5, 4, 100, 1'b0, 2);
        run_load(32'h7100, 3, 2, 100, 1'b0, 0);
        chk("t6_words", words_done, 3);
        chk("t6_last_addr", last_addr, 32'h7108);

        repeat (30) begin
            for (int i = 0; i < 16; i++) dat[i] = $urandom;
            cnt = ($urandom_range(9) == 0) ? 0 : int'($urandom_range(12, 1));
            r = int'($urandom_range(9));
            if (r < 6 || cnt == 0) tp = cnt - 1;
            else if (r < 8) tp = int'($urandom_range(cnt - 1));
            else tp = 99;
            run_load($urandom, cnt, tp, int'($urandom_range(100, 25)), 1'($urandom_range(1)), 0);
        end

        @(posedge Clk); #1;
        chk("exp_q_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
